// File: rtl/clkdiv_pkg.sv
// Shared parameters and helpers for the multi-channel programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_DIV_W       = 16;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 3;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/pending divisor, clkout, tick and pend.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W       = CLKDIV_DIV_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             last;

  assign last = (cnt == div_act - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= DIV_W'(DEFAULT_DIV);
      div_pend <= '0;
      pend     <= 1'b0;
      clkout   <= 1'b0;
      tick     <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
      if (wr) begin
        div_act <= wr_div;
        pend    <= 1'b0;
      end else if (pend) begin
        div_act <= div_pend;
        pend    <= 1'b0;
      end
    end else begin
      tick <= last & ~clkout;
      if (last) begin
        cnt    <= '0;
        clkout <= ~clkout;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      // A write landing on the falling boundary is held for the following one.
      if (wr) begin
        div_pend <= wr_div;
        pend     <= 1'b1;
      end else if (last && clkout && pend) begin
        div_act <= div_pend;
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// NCH independent glitch-free programmable clock dividers with write decode and reject flag.
module clk_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIV_W       = CLKDIV_DIV_W,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         en,
  input  logic                   wr_en,
  input  logic [ch_w(NCH)-1:0]   wr_ch,
  input  logic [DIV_W-1:0]       wr_div,
  output logic                   wr_err,
  output logic [NCH-1:0]         clkout,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         pend
);

  localparam int unsigned   CHW   = ch_w(NCH);
  localparam logic [CHW:0]  NCH_L = (CHW+1)'(NCH);

  logic           wr_ok;
  logic [NCH-1:0] wr_sel;

  // Channel index is widened by one bit so NCH itself is representable in the range check.
  assign wr_ok = wr_en && (wr_div != '0) && ({1'b0, wr_ch} < NCH_L);

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_sel[i] = wr_ok && (wr_ch == CHW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[g]),
      .wr     (wr_sel[g]),
      .wr_div (wr_div),
      .clkout (clkout[g]),
      .tick   (tick[g]),
      .pend   (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (NCH=4 main instance, NCH=3 for range rejects).
module tb_clk_divider_multi;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic        wr_err;
  logic [3:0]  clkout;
  logic [3:0]  tick;
  logic [3:0]  pend;

  logic [2:0]  en3;
  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [15:0] wr_div3;
  logic        wr_err3;
  logic [2:0]  clkout3;
  logic [2:0]  tick3;
  logic [2:0]  pend3;

  int tests = 0;
  int fails = 0;

  logic [31:0] co, tk, pd;
  logic        oth;

  clk_divider_multi #(
    .NCH         (4),
    .DIV_W       (16),
    .DEFAULT_DIV (3)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .wr_err (wr_err),
    .clkout (clkout),
    .tick   (tick),
    .pend   (pend)
  );

  clk_divider_multi #(
    .NCH         (3),
    .DIV_W       (16),
    .DEFAULT_DIV (3)
  ) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en3),
    .wr_en  (wr_en3),
    .wr_ch  (wr_ch3),
    .wr_div (wr_div3),
    .wr_err (wr_err3),
    .clkout (clkout3),
    .tick   (tick3),
    .pend   (pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples n cycles of one channel, oldest sample in the most significant position.
  task automatic capture(input int n, input logic [1:0] ch,
                         output logic [31:0] c, output logic [31:0] t,
                         output logic [31:0] p, output logic o);
    logic [3:0] mask;
    c = '0; t = '0; p = '0; o = 1'b0;
    mask = ~(4'b0001 << ch);
    for (int k = 0; k < n; k++) begin
      step();
      c = {c[30:0], clkout[ch]};
      t = {t[30:0], tick[ch]};
      p = {p[30:0], pend[ch]};
      o = o | (|((clkout | tick) & mask));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    en3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;

    // Reset state
    repeat (2) step();
    chk("rst_clkout",  32'(clkout),  32'd0);
    chk("rst_tick",    32'(tick),    32'd0);
    chk("rst_pend",    32'(pend),    32'd0);
    chk("rst_wr_err",  32'(wr_err),  32'd0);
    chk("rst_clkout3", 32'(clkout3), 32'd0);
    rst_n = 1'b1;
    step();

    // Default divisor 3 on ch0
    en = 4'b0001;
    capture(12, 2'd0, co, tk, pd, oth);
    chk("ch0_div3_clk",  co, 32'(12'b001110001110));
    chk("ch0_div3_tick", tk, 32'(12'b001000001000));
    chk("ch0_div3_oth",  32'(oth), 32'd0);

    // Write ch1 while disabled, then run at clk/2
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
    step();
    wr_en = 1'b0;
    chk("wr_dis_pend1", 32'(pend[1]), 32'd0);
    chk("wr_dis_err",   32'(wr_err),  32'd0);
    en = 4'b0010;
    capture(8, 2'd1, co, tk, pd, oth);
    chk("ch1_div1_clk",  co, 32'(8'b10101010));
    chk("ch1_div1_tick", tk, 32'(8'b10101010));
    chk("ch1_div1_pend", pd, 32'd0);
    chk("ch1_div1_oth",  32'(oth), 32'd0);
    en = 4'b0000;
    step();
    chk("all_off_clk", 32'(clkout), 32'd0);

    // ch0 div 3 -> 5 written mid-high-phase
    en = 4'b0001;
    capture(3, 2'd0, co, tk, pd, oth);
    chk("ch0_start_clk", co, 32'(3'b001));
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd5;
    step();
    wr_en = 1'b0;
    chk("wr5_pend0", 32'(pend[0]),   32'd1);
    chk("wr5_clk0",  32'(clkout[0]), 32'd1);
    capture(17, 2'd0, co, tk, pd, oth);
    chk("div5_clk",  co, 32'(17'b10000011111000001));
    chk("div5_tick", tk, 32'(17'b00000010000000001));
    chk("div5_pend", pd, 32'(17'b10000000000000000));

    // Write on the falling boundary, overwritten before the next one
    repeat (4) step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd2;
    step();
    wr_en = 1'b0;
    chk("bnd_pend0", 32'(pend[0]),   32'd1);
    chk("bnd_clk0",  32'(clkout[0]), 32'd0);
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd4;
    step();
    wr_en = 1'b0;
    capture(20, 2'd0, co, tk, pd, oth);
    chk("div4_clk",  co, 32'(20'b00111110000111100001));
    chk("div4_tick", tk, 32'(20'b00100000000100000001));
    chk("div4_pend", pd, 32'(20'b11111110000000000000));

    // Rejected writes: zero divisor, out-of-range channel
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd0;
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 16'd5;
    step();
    wr_en = 1'b0; wr_en3 = 1'b0;
    chk("err_div0",      32'(wr_err),  32'd1);
    chk("err_ch_range",  32'(wr_err3), 32'd1);
    chk("err_pend",      32'(pend),    32'd0);
    chk("err_pend3",     32'(pend3),   32'd0);
    wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_div3 = 16'd5;
    step();
    wr_en3 = 1'b0;
    chk("err_div0_end",  32'(wr_err),  32'd0);
    chk("ok_ch2_err3",   32'(wr_err3), 32'd0);
    capture(6, 2'd0, co, tk, pd, oth);
    chk("after_err_clk",  co, 32'(6'b100001));
    chk("after_err_tick", tk, 32'(6'b000001));

    // en dropped mid-period with a pending divisor
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd2;
    step();
    wr_en = 1'b0;
    chk("pre_off_pend0", 32'(pend[0]),   32'd1);
    chk("pre_off_clk0",  32'(clkout[0]), 32'd1);
    en = 4'b0000;
    step();
    chk("off_clk",  32'(clkout), 32'd0);
    chk("off_tick", 32'(tick),   32'd0);
    chk("off_pend", 32'(pend),   32'd0);
    en = 4'b0001;
    capture(6, 2'd0, co, tk, pd, oth);
    chk("div2_clk",  co, 32'(6'b011001));
    chk("div2_tick", tk, 32'(6'b010001));

    // Asynchronous reset mid-period, then default divisor again
    chk("pre_rst_tick0", 32'(tick[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk",  32'(clkout), 32'd0);
    chk("async_rst_tick", 32'(tick),   32'd0);
    #2 rst_n = 1'b1;
    capture(9, 2'd0, co, tk, pd, oth);
    chk("post_rst_clk",  co, 32'(9'b001110001));
    chk("post_rst_tick", tk, 32'(9'b001000001));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Parametrised multi-channel programmable clock divider: the successor to the fixed single-output divider. It derives NCH independent divided clocks (and matching one-cycle tick strobes) from the 100 MHz board clock. Each channel has a per-channel enable and a runtime-writable divisor that takes effect only at a period boundary, so outputs never glitch. It sits between the board oscillator and the slow peripherals (display scan, debouncers, LED blinkers).

## Interface
- NCH, 4, number of output channels (1..16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 3, half-period divisor loaded at reset (1..2^DIV_W-1)

- clk  in  1  100 MHz board clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel run enable
- wr_en  in  1  divisor write strobe, one cycle
- wr_ch  in  $clog2(NCH) (min 1)  target channel of write
- wr_div  in  DIV_W  new half-period divisor
- wr_err  out  1  one-cycle pulse: rejected write (wr_div==0 or wr_ch>=NCH)
- clkout  out  NCH  divided clocks, 50 % duty, period 2*div_act
- tick  out  NCH  one-cycle strobe coincident with each clkout rising edge
- pend  out  NCH  channel holds a divisor not yet applied

## Operation
- Per channel: cnt (DIV_W), div_act, div_pend, pend flag, clkout reg, tick reg.
- Reset: cnt=0, div_act=DEFAULT_DIV, div_pend=0, pend=0, clkout=0, tick=0, wr_err=0.
- Running (en=1): cnt increments each cycle; when cnt==div_act-1: cnt<=0, clkout toggles. tick=1 on the cycle clkout goes 0->1, else 0.
- div_act=1: clkout toggles every cycle (clk/2), tick every second cycle.
- Valid write, channel running: div_pend<=wr_div, pend<=1. Applied (div_act<=div_pend, pend<=0) at the cycle clkout toggles 1->0 (full-period boundary), cnt restarts at 0.
- Valid write, channel disabled: div_act<=wr_div directly, pend stays 0.
- Second write while pend=1: overwrites div_pend; only the last value is applied.
- Write in the same cycle as a boundary: stored as pending, applied at the NEXT boundary, never the concurrent one.
- Invalid write: no state change, wr_err=1 next cycle.
- en falling: next cycle cnt=0, clkout=0, tick=0; any pending value applied to div_act immediately.
- Channels are fully independent; no phase alignment between channels.

## Timing
- All outputs registered; no combinational input-to-output path.
- en first sampled high at edge E0 (cnt=0): clkout and tick rise at edge E(div_act-1), i.e. div_act cycles of latency after en is sampled.
- High phase and low phase each exactly div_act cycles; period 2*div_act cycles.
- wr_err and pend update one cycle after the wr_en edge.
- Reset asserted mid-period: all outputs 0 immediately (asynchronous); divisor reverts to DEFAULT_DIV.
- cnt arithmetic is unsigned DIV_W; cnt never exceeds div_act-1, so no wrap handling is needed.

## Structure
- Package clkdiv_pkg: DIV_W default, DEFAULT_DIV, channel-index width function (max(1,$clog2(NCH))).
- Sub-module clk_div_channel (one counter, divisor regs, clkout/tick/pend), instantiated NCH times in a generate loop. The top level decodes writes, checks validity and drives wr_err.

## Test plan
- Reset with DEFAULT_DIV=3, en=4'b0001 -> ch0 clkout period 6 cycles, high 3 cycles; tick every 6 cycles; other channels held 0.
- Write ch1 div=1 while disabled, then enable -> clkout1 toggles every cycle, tick1 every 2 cycles, pend1 never set.
- ch0 running at div 3, write div=5 mid-high-phase -> pend0=1; current period completes at 6 cycles; the following periods are 10 cycles; pend0 clears at the boundary.
- Write coinciding with a 1->0 boundary, then a second write before the next boundary -> only the second value is applied, one full old period later.
- wr_div=0 and wr_ch=NCH -> wr_err pulses one cycle each; all div_act values unchanged.
- Drop en mid-period and assert rst_n=0 asynchronously mid-period -> clkout/tick go 0 (next cycle for en, immediately for reset); after reset, divisor is back to 3.
